pid_mac: RTL and testbench

Sequential multiply-accumulate engine for the servo controller's incremental difference equation: y[n] = (u[n-1] << 8) + k0·e[n] + k1·e[n-1] + k2·e[n-2]. It sits directly upstream of the 40-bit-to-8-bit scaling/saturation stage. Its 40-bit signed y feeds that stage's input, and that stage's 8-bit signed result returns here as u_prev. One hardware multiplier is time-shared over three cycles per sample.

---
 rtl/pid_mac.sv | 111 +++++++++++
 tb/tb_pid_mac.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pid_mac.sv
// Time-shared MAC for y = (u_prev<<8) + k0*e0 + k1*e1 + k2*e2, one multiplier over three cycles.
// Latency 4 clocks start-to-done; start is ignored while busy, clr wins over start.
module pid_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        e_in,
  input  logic [DATA_W-1:0]        k0,
  input  logic [DATA_W-1:0]        k1,
  input  logic [DATA_W-1:0]        k2,
  input  logic [ACC_W-33:0]        u_prev,
  output logic [ACC_W-1:0]         y,
  output logic                     done,
  output logic                     busy
);

  localparam int UW = ACC_W - 32;
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, DONE} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       e0, e1, e2;
  logic [DATA_W-1:0]       k0r, k1r, k2r;
  logic [DATA_W-1:0]       sel_k, sel_e;
  logic signed [PW-1:0]    mul_a, mul_b, prod;
  logic [ACC_W-1:0]        acc, prod_ext, u_ext;

  // Operand select for the single shared multiplier.
  always_comb begin
    sel_k = k0r;
    sel_e = e0;
    case (state)
      MAC1: begin sel_k = k1r; sel_e = e1; end
      MAC2: begin sel_k = k2r; sel_e = e2; end
      default: ;
    endcase
    mul_a = {{DATA_W{sel_k[DATA_W-1]}}, sel_k};
    mul_b = {{DATA_W{sel_e[DATA_W-1]}}, sel_e};
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign u_ext    = {{(ACC_W-UW-8){u_prev[UW-1]}}, u_prev, 8'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      e0    <= '0;
      e1    <= '0;
      e2    <= '0;
      k0r   <= '0;
      k1r   <= '0;
      k2r   <= '0;
      acc   <= '0;
      y     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      e0    <= '0;
      e1    <= '0;
      e2    <= '0;
      acc   <= '0;
      y     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            e2    <= e1;
            e1    <= e0;
            e0    <= e_in;
            k0r   <= k0;
            k1r   <= k1;
            k2r   <= k2;
            acc   <= u_ext;
            busy  <= 1'b1;
            state <= MAC0;
          end
        end
        MAC0: begin
          acc   <= acc + prod_ext;
          state <= MAC1;
        end
        MAC1: begin
          acc   <= acc + prod_ext;
          state <= MAC2;
        end
        MAC2: begin
          acc   <= acc + prod_ext;
          state <= DONE;
        end
        DONE: begin
          y     <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_mac.sv
// Directed bench for pid_mac: stimulus pushes expected y into a queue, a monitor pops on done.
module tb_pid_mac;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               clr;
  logic [15:0]        e_in, k0, k1, k2;
  logic [7:0]         u_prev;
  logic [39:0]        y;
  logic               done;
  logic               busy;

  int tests;
  int fails;
  logic [39:0] sb[$];
  logic [39:0] last_y;

  pid_mac #(.DATA_W(16), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .e_in(e_in), .k0(k0), .k1(k1), .k2(k2), .u_prev(u_prev),
    .y(y), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act, $signed(req), req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 40'd1, 40'd0);
      end else begin
        check("y_on_done", y, sb.pop_front());
      end
    end
  end

  // mode: 0 plain, 1 extra start in MAC1, 2 reset in MAC1, 3 clr in MAC2
  task automatic run_op(input logic [15:0] e, input logic [15:0] c0, input logic [15:0] c1,
                        input logic [15:0] c2, input logic [7:0] u, input logic [39:0] exp, input int mode);
    int busy_cnt;
    bit seen;
    @(negedge clk);
    e_in = e; k0 = c0; k1 = c1; k2 = c2; u_prev = u; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e_in = 16'($urandom); k0 = 16'($urandom); k1 = 16'($urandom);
    k2 = 16'($urandom); u_prev = 8'($urandom);
    if (mode < 2) sb.push_back(exp);
    busy_cnt = 0;
    seen = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        check("latency", 40'(k - 1), 40'd4);
        check("busy_cycles", 40'(busy_cnt), 40'd4);
      end else begin
        check("y_hold", y, last_y);
      end
      if (mode == 1 && k == 2) begin
        start = 1'b1;
        e_in  = 16'd99;
        @(posedge clk);
        #1 start = 1'b0;
      end
      if (mode == 2 && k == 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_y", y, 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_done", 40'(done), 40'd0);
        last_y = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      if (mode == 3 && k == 3) begin
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_y", y, 40'd0);
        check("clr_busy", 40'(busy), 40'd0);
        check("clr_done", 40'(done), 40'd0);
        last_y = '0;
      end
    end
    if (mode < 2) begin
      if (!seen) check("done_timeout", 40'd0, 40'd1);
      last_y = exp;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    last_y = '0;
  endtask

  initial begin
    tests = 0; fails = 0; last_y = '0;
    rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    e_in = '0; k0 = '0; k1 = '0; k2 = '0; u_prev = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", y, 40'd0);
    check("reset_done", 40'(done), 40'd0);
    check("reset_busy", 40'(busy), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd5, 16'd1, 16'd0, 16'd0, 8'd0, 40'd5, 0);
    run_op(16'd100, 16'd256, 16'd0, 16'd0, 8'd0, 40'd25600, 0);

    pulse_clr();
    run_op(16'd1, 16'd1, 16'd10, 16'd100, 8'd0, 40'd1, 0);
    run_op(16'd2, 16'd1, 16'd10, 16'd100, 8'd0, 40'd12, 0);
    run_op(16'd3, 16'd1, 16'd10, 16'd100, 8'd0, 40'd123, 0);

    run_op(16'h8000, 16'h8000, 16'd0, 16'd0, 8'hFF, 40'd1073741568, 0);
    run_op(16'd0, 16'd0, 16'd0, 16'd0, 8'd127, 40'd32512, 0);
    run_op(16'd0, 16'd0, 16'd0, 16'd0, 8'h80, -40'sd32768, 0);

    // Extra start during MAC1 must not shift history: next e1 is still 7.
    pulse_clr();
    run_op(16'd7, 16'd1, 16'd1000, 16'd0, 8'd0, 40'd7, 1);
    run_op(16'd3, 16'd1, 16'd1000, 16'd0, 8'd0, 40'd7003, 0);

    run_op(16'd50, 16'd1, 16'd1, 16'd1, 8'd0, 40'd0, 2);
    repeat (6) @(negedge clk);
    run_op(16'd9, 16'd1, 16'd0, 16'd0, 8'd0, 40'd9, 0);
    run_op(16'd50, 16'd1, 16'd1, 16'd1, 8'd0, 40'd0, 3);
    repeat (6) @(negedge clk);
    run_op(16'd4, 16'd1, 16'd5, 16'd6, 8'd0, 40'd4, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 40'(sb.size()), 40'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
